// File: rtl/hdr_pattern_gen_pkg.sv
// rtl/hdr_pattern_gen_pkg.sv - shared constants and encodings for the HDR pattern generator
package hdr_pattern_gen_pkg;

  localparam int RESTART_PHASES = 6;
  localparam int EXIT_PHASES    = 10;
  localparam int PH_W           = 4;

  localparam logic KIND_RESTART = 1'b0;
  localparam logic KIND_EXIT    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hdr_pattern_gen_phase_timer.sv
// rtl/hdr_pattern_gen_phase_timer.sv - per-phase cycle counter with terminal-count pulse
module hdr_phase_timer #(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hdr_pattern_gen.sv
// rtl/hdr_pattern_gen.sv - controller-side I3C HDR Restart / HDR Exit pattern generator
module hdr_pattern_gen
  import hdr_pattern_gen_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_restart_req,
  input  logic i_exit_req,
  output logic o_scl,
  output logic o_sda,
  output logic o_drive,
  output logic o_busy,
  output logic o_done,
  output logic o_kind
);

  state_e          state;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] last_ph;
  logic [1:0]      lvl;
  logic            tc;

  hdr_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk  (i_sys_clk),
    .rst_n(i_sys_rst),
    .clr  (state != ST_RUN),
    .en   (state == ST_RUN),
    .tc   (tc)
  );

  assign last_ph = (o_kind == KIND_EXIT) ? PH_W'(EXIT_PHASES - 1) : PH_W'(RESTART_PHASES - 1);

  // {SCL, SDA} for the current phase; SDA toggles under SCL low, then SCL rises last
  always_comb begin
    lvl = 2'b11;
    if (o_kind == KIND_EXIT) begin
      case (ph)
        4'd0, 4'd2, 4'd4, 4'd6: lvl = 2'b01;
        4'd1, 4'd3, 4'd5, 4'd7: lvl = 2'b00;
        4'd8:                   lvl = 2'b10;
        default:                lvl = 2'b11;
      endcase
    end else begin
      case (ph)
        4'd0, 4'd2, 4'd4: lvl = 2'b01;
        4'd1, 4'd3:       lvl = 2'b00;
        default:          lvl = 2'b11;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state   <= ST_IDLE;
      ph      <= '0;
      o_scl   <= 1'b1;
      o_sda   <= 1'b1;
      o_drive <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_kind  <= KIND_RESTART;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_drive <= 1'b0;
          o_scl   <= 1'b1;
          o_sda   <= 1'b1;
          if (i_exit_req || i_restart_req) begin
            o_kind <= i_exit_req ? KIND_EXIT : KIND_RESTART;
            ph     <= '0;
            o_busy <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          o_drive        <= 1'b1;
          {o_scl, o_sda} <= lvl;
          if (tc) begin
            if (ph == last_ph) begin
              ph     <= '0;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              ph <= ph + 1'b1;
            end
          end
        end
        default: begin
          // DONE cycle shows the final (1,1) with drive still high; release from here
          o_drive <= 1'b0;
          o_scl   <= 1'b1;
          o_sda   <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_pattern_gen.sv
// tb/tb_hdr_pattern_gen.sv - randomized self-checking bench for hdr_pattern_gen
module tb_hdr_pattern_gen;

  localparam int PC0 = 4;
  localparam int PC1 = 2;

  logic clk;
  logic rst_n       [2];
  logic restart_req [2];
  logic exit_req    [2];
  logic scl [2], sda [2], drive [2], busy [2], done [2], kind [2];
  logic [5:0] obs [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_kind [2];

  int r_sda [6]  = '{1, 0, 1, 0, 1, 1};
  int e_sda [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1};

  hdr_pattern_gen #(.PHASE_CYCLES(PC0), .CNT_W(8)) u_dut0 (
    .i_sys_clk(clk), .i_sys_rst(rst_n[0]),
    .i_restart_req(restart_req[0]), .i_exit_req(exit_req[0]),
    .o_scl(scl[0]), .o_sda(sda[0]), .o_drive(drive[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_kind(kind[0])
  );

  hdr_pattern_gen #(.PHASE_CYCLES(PC1), .CNT_W(8)) u_dut1 (
    .i_sys_clk(clk), .i_sys_rst(rst_n[1]),
    .i_restart_req(restart_req[1]), .i_exit_req(exit_req[1]),
    .o_scl(scl[1]), .o_sda(sda[1]), .o_drive(drive[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_kind(kind[1])
  );

  assign obs[0] = {drive[0], scl[0], sda[0], busy[0], done[0], kind[0]};
  assign obs[1] = {drive[1], scl[1], sda[1], busy[1], done[1], kind[1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got {drv,scl,sda,busy,done,kind}=%b expected %b", tag, got, exp);
    end
  endtask

  // Cycle k after the request cycle (k=0): busy 1..N*P, phases visible 2..N*P+1, done at N*P+1
  function automatic logic [5:0] model(input logic knd, input logic pk, input int pc, input int k);
    int n, p;
    logic d, c, s, b, dn, kk;
    n  = knd ? 10 : 6;
    d  = (k >= 2) && (k <= n * pc + 1);
    b  = (k >= 1) && (k <= n * pc);
    dn = (k == n * pc + 1);
    kk = (k == 0) ? pk : knd;
    c  = 1'b1;
    s  = 1'b1;
    if (d) begin
      p = (k - 2) / pc;
      c = (p >= n - (knd ? 2 : 1));
      s = knd ? (e_sda[p] != 0) : (r_sda[p] != 0);
    end
    return {d, c, s, b, dn, kk};
  endfunction

  // sel: 0 restart, 1 exit, 2 both; abort_k >= 0 resets the unit mid-pattern in that cycle
  task automatic run_pat(input int d, input int sel, input bit noise, input int abort_k);
    int pc, n, last;
    logic knd;
    pc   = (d == 0) ? PC0 : PC1;
    knd  = (sel != 0);
    n    = knd ? 10 : 6;
    last = n * pc + 2;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) begin
        restart_req[d] = (sel != 1);
        exit_req[d]    = (sel != 0);
      end else if (noise && k <= n * pc + 1) begin
        restart_req[d] = 1'($urandom_range(0, 1));
        exit_req[d]    = 1'($urandom_range(0, 1));
      end else begin
        restart_req[d] = 1'b0;
        exit_req[d]    = 1'b0;
      end
      @(negedge clk);
      check_eq($sformatf("u%0d sel%0d k%0d", d, sel, k), obs[d], model(knd, prev_kind[d], pc, k));
      if (k == abort_k) begin
        #2 rst_n[d] = 1'b0;
        #1 check_eq($sformatf("u%0d abort-edge", d), obs[d], 6'b011000);
        restart_req[d] = 1'b0;
        exit_req[d]    = 1'b0;
        @(posedge clk);
        #1 rst_n[d] = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          check_eq($sformatf("u%0d post-abort %0d", d, j), obs[d], 6'b011000);
        end
        prev_kind[d] = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    prev_kind[d] = knd;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]       = 1'b0;
      restart_req[i] = 1'b0;
      exit_req[i]    = 1'b0;
      prev_kind[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("u0 reset", obs[0], 6'b011000);
    check_eq("u1 reset", obs[1], 6'b011000);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;

    run_pat(0, 0, 1'b0, -1);
    run_pat(0, 1, 1'b0, -1);
    run_pat(0, 2, 1'b1, -1);
    run_pat(1, 0, 1'b0, -1);
    run_pat(1, 1, 1'b1, -1);
    run_pat(0, 1, 1'b0, 2 + 5 * PC0 + 1);

    for (int it = 0; it < 24; it++) begin
      int d, gap;
      d   = $urandom_range(0, 1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_eq($sformatf("u%0d idle gap", d), obs[d], {5'b01100, prev_kind[d]});
        @(posedge clk);
        #1;
      end
      run_pat(d, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
